sha256_block_sched: RTL and testbench
=====================================

Name: sha256_block_sched

Overview:
- Sequences the SHA-256 compression datapath over a message made of one or more pre-padded 512-bit blocks.
- Accepts blocks through a valid/ready handshake and drives the round core with load, enable and round index.
- Keeps the chaining value H0..H7 and adds the core's working variables into it at the end of each block.
- Presents the final 256-bit digest, held until acknowledged. Sits between the message padder and the round core inside top.

Parameters:
- ROUNDS, 64, compression rounds per block (also the round counter terminal value + 1).
- IV, 256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19, initial hash value, H0 in the MSBs.

Ports:
- clk  in  1  clock, all state on rising edge.
- reset  in  1  asynchronous, active-low reset.
- blk_valid  in  1  padder presents a block.
- blk_ready  out  1  scheduler can accept a block.
- blk_data  in  512  padded block, W0 in the MSBs.
- blk_last  in  1  final block of the message; sampled with blk_data.
- abort  in  1  synchronous cancel of the current message.
- core_load  out  1  core loads core_block and initialises a..h from core_init.
- core_block  out  512  registered copy of the accepted block.
- core_init  out  256  current chaining value H.
- core_en  out  1  core executes one round this cycle.
- core_rnd  out  6  round index for K/W selection.
- core_state  in  256  core working variables a..h (a in MSBs), valid after the last round.
- digest  out  256  final hash, H0 in the MSBs.
- digest_valid  out  1  digest is valid.
- digest_ack  in  1  consumer has taken the digest.

Behaviour:
- Reset (reset low, asynchronous):
  - State IDLE, H = IV, first flag = 1, round counter = 0.
  - blk_ready = 1; core_load = core_en = digest_valid = 0; core_block = 0; digest = 0.
- FSM states: IDLE, LOAD, ROUND, UPDATE, DONE. blk_ready = 1 only in IDLE.
- IDLE:
  - On blk_valid & blk_ready: register blk_data into core_block and latch blk_last.
  - If first = 1, set H = IV. Then go to LOAD.
  - With no handshake, stay in IDLE.
- LOAD (1 cycle):
  - core_load = 1, core_init = H. Clear the round counter, go to ROUND.
- ROUND (ROUNDS cycles):
  - core_en = 1, core_rnd = counter; counter increments each cycle.
  - When counter == ROUNDS-1, go to UPDATE. The counter never wraps inside ROUND.
- UPDATE (1 cycle):
  - Hi = Hi + core_state word i, computed per 32-bit word, mod 2^32, carries discarded.
  - If the latched last = 1: go to DONE and set first = 1.
  - Otherwise: go to IDLE and set first = 0.
- DONE:
  - digest = H, digest_valid = 1, both held stable.
  - On digest_ack: digest_valid drops the next cycle, go to IDLE.
  - digest_ack outside DONE is ignored.
- Latency:
  - Accept edge at cycle 0: LOAD in cycle 1, ROUND in cycles 2..65, UPDATE in cycle 66.
  - digest_valid rises in cycle 67 for ROUNDS = 64.
  - For N blocks: ROUNDS+3 cycles per block plus the IDLE handshake cycles.
- abort:
  - In any non-IDLE state: next state IDLE, first = 1, core_en = core_load = 0, digest_valid = 0.
  - H is not committed; the next block starts from IV.
  - abort has priority over a same-cycle digest_ack or UPDATE.
  - abort in IDLE blocks acceptance that cycle (blk_ready forced 0) and sets first = 1.
- Mid-message blocks: blk_ready reasserts in the cycle after UPDATE. The padder may stall between blocks indefinitely; H is held.
- Mid-operation reset returns all state to reset values immediately; no partial digest is ever flagged valid.

Test Plan:
- Single block "abc" (616263 80 00.. 18 length), blk_last = 1 → digest_valid at cycle 67 after accept; digest = ba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad.
- Two-block "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq" with a 5-cycle blk_valid gap between blocks → digest = 248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1. Second core_init equals H after block 1, not IV.
- Back-to-back messages: hold digest_ack low for 10 cycles, then ack, then send "abc" again → digest stable while held, blk_ready = 0 throughout DONE, second digest identical (IV restored).
- Abort at core_rnd = 30 of block 1 of 2, then send "abc" → no digest_valid for the aborted message; the "abc" digest is correct (first flag reset).
- Reset asserted at core_rnd = 40 → outputs return to reset values asynchronously. After release, blk_ready = 1 and an "abc" run completes correctly.
- Handshake checks: blk_valid held high during ROUND → no second accept; core_rnd runs 0..63 exactly once per block, core_en high exactly 64 cycles, core_load high exactly 1 cycle.

Source files
------------

// File: rtl/sha256_block_sched.sv
// SHA-256 block scheduler: accepts padded 512-bit blocks, sequences the round core
// through load/round/update, keeps the chaining value H and presents the final digest.
module sha256_block_sched #(
  parameter int           ROUNDS = 64,
  parameter logic [255:0] IV     = 256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         blk_valid,
  output logic         blk_ready,
  input  logic [511:0] blk_data,
  input  logic         blk_last,
  input  logic         abort,
  output logic         core_load,
  output logic [511:0] core_block,
  output logic [255:0] core_init,
  output logic         core_en,
  output logic [5:0]   core_rnd,
  input  logic [255:0] core_state,
  output logic [255:0] digest,
  output logic         digest_valid,
  input  logic         digest_ack,
  output logic [2:0]   fsm_state
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LOAD   = 3'd1;
  localparam logic [2:0] S_ROUND  = 3'd2;
  localparam logic [2:0] S_UPDATE = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;

  localparam logic [5:0] RND_LAST = 6'(ROUNDS - 1);

  logic [2:0]   state, state_nxt;
  logic [5:0]   rnd_q;
  logic [255:0] h_q, h_sum, digest_q;
  logic [511:0] blk_q;
  logic         first_q, last_q;
  logic         accept;

  // Handshake: a block transfers on a rising clk edge where blk_valid and blk_ready
  // are both high; blk_data/blk_last are sampled only on that edge.
  assign blk_ready = (state == S_IDLE) && !abort;
  assign accept    = blk_valid && blk_ready;

  assign core_load    = (state == S_LOAD);
  assign core_en      = (state == S_ROUND);
  assign core_rnd     = rnd_q;
  assign core_init    = h_q;
  assign core_block   = blk_q;
  assign digest       = digest_q;
  assign digest_valid = (state == S_DONE);
  assign fsm_state    = state;

  // Per-word modular add of the core's working variables into H.
  always_comb begin
    h_sum = '0;
    for (int i = 0; i < 8; i++) begin
      h_sum[32*i +: 32] = h_q[32*i +: 32] + core_state[32*i +: 32];
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (accept) state_nxt = S_LOAD;
      S_LOAD:   state_nxt = S_ROUND;
      S_ROUND:  if (rnd_q == RND_LAST) state_nxt = S_UPDATE;
      S_UPDATE: state_nxt = last_q ? S_DONE : S_IDLE;
      S_DONE:   if (digest_ack) state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
    if (abort) state_nxt = S_IDLE;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= S_IDLE;
      rnd_q    <= '0;
      h_q      <= IV;
      digest_q <= '0;
      blk_q    <= '0;
      first_q  <= 1'b1;
      last_q   <= 1'b0;
    end else begin
      state <= state_nxt;
      if (abort) begin
        // H is left as is; first forces the next block to restart from IV.
        first_q <= 1'b1;
      end else begin
        case (state)
          S_IDLE: begin
            if (accept) begin
              blk_q  <= blk_data;
              last_q <= blk_last;
              if (first_q) h_q <= IV;
            end
          end
          S_LOAD:  rnd_q <= '0;
          S_ROUND: if (rnd_q != RND_LAST) rnd_q <= rnd_q + 6'd1;
          S_UPDATE: begin
            h_q     <= h_sum;
            first_q <= last_q;
            if (last_q) digest_q <= h_sum;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sha256_block_sched.sv
// Directed bench for sha256_block_sched with a behavioural SHA-256 round core
// feeding core_state, plus table-driven message vectors and corner-case sequences.
module tb_sha256_block_sched;

  localparam logic [255:0] IV = 256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;
  localparam logic [511:0] ABC  = {32'h61626380, 448'h0, 32'h00000018};
  localparam logic [511:0] TWO0 = {448'h6162636462636465636465666465666765666768666768696768696a68696a6b696a6b6c6a6b6c6d6b6c6d6e6c6d6e6f6d6e6f706e6f7071, 64'h8000000000000000};
  localparam logic [511:0] TWO1 = {448'h0, 64'h00000000000001c0};
  localparam logic [255:0] D_ABC = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
  localparam logic [255:0] D_TWO = 256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;

  localparam logic [31:0] K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

  typedef logic [31:0] w_arr_t [64];

  typedef struct {
    logic [511:0] b0;
    logic [511:0] b1;
    int           nblk;
    int           gap;
    logic [255:0] exp;
  } msg_t;

  // ---------------- clock / reset / DUT ----------------
  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         blk_valid = 1'b0, blk_last = 1'b0, abort = 1'b0, digest_ack = 1'b0;
  logic [511:0] blk_data = '0;
  logic         blk_ready, core_load, core_en, digest_valid;
  logic [511:0] core_block;
  logic [255:0] core_init, core_state, digest;
  logic [5:0]   core_rnd;
  logic [2:0]   fsm_state;

  always #5 clk = ~clk;

  sha256_block_sched dut (
    .clk(clk), .reset(reset),
    .blk_valid(blk_valid), .blk_ready(blk_ready), .blk_data(blk_data), .blk_last(blk_last),
    .abort(abort),
    .core_load(core_load), .core_block(core_block), .core_init(core_init),
    .core_en(core_en), .core_rnd(core_rnd), .core_state(core_state),
    .digest(digest), .digest_valid(digest_valid), .digest_ack(digest_ack),
    .fsm_state(fsm_state)
  );

  // ---------------- behavioural round core ----------------
  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic w_arr_t expand(input logic [511:0] b);
    w_arr_t w;
    logic [31:0] s0, s1;
    for (int i = 0; i < 16; i++) w[i] = b[511 - 32*i -: 32];
    for (int i = 16; i < 64; i++) begin
      s0 = rotr(w[i-15], 7) ^ rotr(w[i-15], 18) ^ (w[i-15] >> 3);
      s1 = rotr(w[i-2], 17) ^ rotr(w[i-2], 19) ^ (w[i-2] >> 10);
      w[i] = s1 + w[i-7] + s0 + w[i-16];
    end
    return w;
  endfunction

  function automatic logic [255:0] addw(input logic [255:0] x, input logic [255:0] y);
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[32*i +: 32] = x[32*i +: 32] + y[32*i +: 32];
    return r;
  endfunction

  logic [31:0]  ma, mb, mc, md, me, mf, mg, mh;
  logic [31:0]  t1, t2;
  w_arr_t       mw;
  logic [255:0] fin_q[$];

  assign core_state = {ma, mb, mc, md, me, mf, mg, mh};

  always @(posedge clk) begin
    if (core_load) begin
      {ma, mb, mc, md, me, mf, mg, mh} <= core_init;
      mw <= expand(core_block);
    end else if (core_en) begin
      t1 = mh + (rotr(me, 6) ^ rotr(me, 11) ^ rotr(me, 25)) + ((me & mf) ^ (~me & mg)) + K[core_rnd] + mw[core_rnd];
      t2 = (rotr(ma, 2) ^ rotr(ma, 13) ^ rotr(ma, 22)) + ((ma & mb) ^ (ma & mc) ^ (mb & mc));
      {ma, mb, mc, md, me, mf, mg, mh} <= {t1 + t2, ma, mb, mc, md + t1, me, mf, mg};
      if (core_rnd == 6'd63) fin_q.push_back({t1 + t2, ma, mb, mc, md + t1, me, mf, mg});
    end
  end

  // ---------------- monitor (cumulative counters) ----------------
  int load_cnt = 0, en_cnt = 0, rnd_bad = 0, acc_cnt = 0, dv_cnt = 0, rnd_exp = 0;
  logic dv_prev = 1'b0;
  logic [255:0] init_log[$];

  always @(negedge clk) begin
    if (core_load) begin
      load_cnt++;
      rnd_exp = 0;
      init_log.push_back(core_init);
    end
    if (core_en) begin
      en_cnt++;
      if (int'(core_rnd) != rnd_exp) rnd_bad++;
      rnd_exp++;
    end
    if (blk_valid && blk_ready) acc_cnt++;
    if (digest_valid && !dv_prev) dv_cnt++;
    dv_prev = digest_valid;
  end

  // ---------------- scoreboard ----------------
  int checks = 0, errors = 0;
  logic [255:0] exp_q[$];

  task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic send_block(input logic [511:0] d, input logic l, input logic hold);
    int n = 0;
    @(posedge clk); #1;
    blk_data = d; blk_last = l; blk_valid = 1'b1;
    while (!blk_ready && n < 300) begin @(posedge clk); #1; n++; end
    if (!blk_ready) chk("accept_timeout", 1, 0);
    @(posedge clk); #1;
    if (!hold) blk_valid = 1'b0;
  endtask

  task automatic wait_ready(output int n);
    n = 0;
    do begin @(negedge clk); n++; end while (!blk_ready && n < 300);
  endtask

  task automatic wait_digest(output int n);
    n = 0;
    do begin @(negedge clk); n++; end while (!digest_valid && n < 300);
  endtask

  task automatic ack_digest();
    @(posedge clk); #1 digest_ack = 1'b1;
    @(posedge clk); #1 digest_ack = 1'b0;
    @(negedge clk);
    chk("dv_drop_after_ack", {digest_valid, blk_ready}, 2'b01);
  endtask

  task automatic run_msg(input msg_t m, input string nm);
    int lat, ld0, en0, bad0, i0, f0;
    ld0 = load_cnt; en0 = en_cnt; bad0 = rnd_bad; i0 = init_log.size(); f0 = fin_q.size();
    exp_q.push_back(m.exp);
    if (m.nblk == 2) begin
      send_block(m.b0, 1'b0, 1'b0);
      wait_ready(lat);
      chk({nm, "_ready_reassert"}, lat, 67);
      repeat (m.gap) @(posedge clk);
      send_block(m.b1, 1'b1, 1'b0);
    end else begin
      send_block(m.b0, 1'b1, 1'b0);
    end
    wait_digest(lat);
    chk({nm, "_latency"}, lat, 67);
    chk({nm, "_digest"}, digest, exp_q.pop_front());
    chk({nm, "_load_cycles"}, load_cnt - ld0, m.nblk);
    chk({nm, "_en_cycles"}, en_cnt - en0, 64 * m.nblk);
    chk({nm, "_rnd_seq"}, rnd_bad - bad0, 0);
    if (init_log.size() > i0) chk({nm, "_init0"}, init_log[i0], IV);
    else chk({nm, "_init0_missing"}, 1, 0);
    if (m.nblk == 2) begin
      if (init_log.size() > i0 + 1 && fin_q.size() > f0)
        chk({nm, "_init1_chain"}, init_log[i0+1], addw(IV, fin_q[f0]));
      else chk({nm, "_init1_missing"}, 1, 0);
    end
    ack_digest();
  endtask

  task automatic wait_round(input int r);
    int n = 0;
    do begin @(negedge clk); n++; end while (!(core_en && int'(core_rnd) == r) && n < 300);
    if (n >= 300) chk("round_wait_timeout", 1, 0);
  endtask

  // ---------------- stimulus ----------------
  msg_t tbl [4];

  initial begin
    int lat, acc0, dv0;
    logic stable;

    tbl[0] = '{b0: ABC,  b1: '0,   nblk: 1, gap: 0, exp: D_ABC};
    tbl[1] = '{b0: TWO0, b1: TWO1, nblk: 2, gap: 5, exp: D_TWO};
    tbl[2] = '{b0: TWO0, b1: TWO1, nblk: 2, gap: 0, exp: D_TWO};
    tbl[3] = '{b0: ABC,  b1: '0,   nblk: 1, gap: 0, exp: D_ABC};

    repeat (3) @(negedge clk);
    chk("reset_ctrl", {blk_ready, core_load, core_en, digest_valid}, 4'b1000);
    chk("reset_data", {core_block, digest, core_rnd}, '0);
    chk("reset_h", core_init, IV);
    reset = 1'b1;

    for (int i = 0; i < 4; i++) run_msg(tbl[i], $sformatf("vec%0d", i));

    // Digest held while the consumer stalls; no new block taken in DONE.
    exp_q.push_back(D_ABC);
    send_block(ABC, 1'b1, 1'b0);
    wait_digest(lat);
    stable = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (!digest_valid || blk_ready || digest !== D_ABC) stable = 1'b0;
    end
    chk("hold_stable", stable, 1'b1);
    chk("hold_digest", digest, exp_q.pop_front());
    ack_digest();
    run_msg(tbl[0], "abc_after_hold");

    // blk_valid left high through the rounds must yield exactly one accept.
    acc0 = acc_cnt;
    send_block(ABC, 1'b1, 1'b1);
    wait_round(20);
    chk("held_valid_ready_low", blk_ready, 1'b0);
    wait_digest(lat);
    #1 blk_valid = 1'b0;
    chk("held_valid_one_accept", acc_cnt - acc0, 1);
    chk("held_valid_digest", digest, D_ABC);
    ack_digest();

    // Abort at round 30 of block 1, then of block 2, each followed by "abc".
    for (int b = 0; b < 2; b++) begin
      dv0 = dv_cnt;
      send_block(TWO0, 1'b0, 1'b0);
      if (b == 1) begin
        wait_ready(lat);
        send_block(TWO1, 1'b1, 1'b0);
      end
      wait_round(30);
      abort = 1'b1;
      @(posedge clk); #1 abort = 1'b0;
      @(negedge clk);
      chk($sformatf("abort%0d_idle", b), {blk_ready, core_en, core_load, digest_valid}, 4'b1000);
      repeat (80) @(negedge clk);
      chk($sformatf("abort%0d_no_digest", b), dv_cnt - dv0, 0);
      run_msg(tbl[0], $sformatf("abc_after_abort%0d", b));
    end

    // Asynchronous reset in the middle of the rounds.
    send_block(ABC, 1'b1, 1'b0);
    wait_round(40);
    #2 reset = 1'b0;
    #1;
    chk("midreset_ctrl", {blk_ready, core_load, core_en, digest_valid}, 4'b1000);
    chk("midreset_data", {core_block, digest, core_rnd}, '0);
    chk("midreset_h", core_init, IV);
    @(negedge clk) reset = 1'b1;
    run_msg(tbl[0], "abc_after_reset");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
